// File: rtl/pix_src_sched.sv
// pix_src_sched: schedules pixel reads from one of two sources toward a sink.
// A frame starts on i_newframe, which latches the source select and decides
// between RUN (forward strobes to the selected source) and BLANK (fallback only).
// A read issued in cycle t is answered by the source in t+1; o_pixel shows it in t+2.
// Optional build macro: PIX_SRC_SCHED_UNDERFLOW_CNT_EN enables the saturating
// underflow event counter. Without it, o_underflow_cnt is tied to 0.
module pix_src_sched #(
  parameter int                          BITS_PER_COLOR = 8,
  parameter logic [3*BITS_PER_COLOR-1:0] FALLBACK_RGB   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_enable,
  input  logic                          i_newline,
  input  logic                          i_newframe,
  input  logic                          i_sel,
  input  logic                          i_blank,
  input  logic                          i_clr_stat,
  output logic                          o_s0_rd,
  output logic                          o_s1_rd,
  output logic                          o_s0_newline,
  output logic                          o_s1_newline,
  output logic                          o_s0_newframe,
  output logic                          o_s1_newframe,
  input  logic [3*BITS_PER_COLOR-1:0]   i_s0_pixel,
  input  logic [3*BITS_PER_COLOR-1:0]   i_s1_pixel,
  input  logic                          i_s0_valid,
  input  logic                          i_s1_valid,
  output logic [3*BITS_PER_COLOR-1:0]   o_pixel,
  output logic                          o_valid,
  output logic                          o_active_sel,
  output logic [1:0]                    o_state,
  output logic                          o_underflow,
  output logic [15:0]                   o_underflow_cnt
);
  localparam int PW = 3*BITS_PER_COLOR;

  typedef enum logic [1:0] {SYNC = 2'd0, RUN = 2'd1, BLANK = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            rd_pend_q;   // a source read was issued last cycle
  logic            rd_sel_q;    // which source that read went to
  logic            blk_pend_q;  // a BLANK-mode request was taken last cycle
  logic [PW-1:0]   pixel_q;
  logic            valid_q;
  logic            uf_q;
  logic            uf_evt;
  logic            run;

  // Next state and source select; strobes use the post-latch select so the
  // switching i_newframe reaches the newly selected source.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    o_s0_rd       = 1'b0;
    o_s1_rd       = 1'b0;
    o_s0_newline  = 1'b0;
    o_s1_newline  = 1'b0;
    o_s0_newframe = 1'b0;
    o_s1_newframe = 1'b0;
    if (i_newframe) begin
      sel_d   = i_sel;
      state_d = i_blank ? BLANK : RUN;
    end
    if (run) begin
      o_s0_rd       = i_enable   & ~sel_d;
      o_s1_rd       = i_enable   &  sel_d;
      o_s0_newline  = i_newline  & ~sel_d;
      o_s1_newline  = i_newline  &  sel_d;
      o_s0_newframe = i_newframe & ~sel_d;
      o_s1_newframe = i_newframe &  sel_d;
    end
  end

  assign run    = (state_q == RUN);
  // Missing data in the response cycle of a read is an underflow.
  assign uf_evt = rd_pend_q & ~(rd_sel_q ? i_s1_valid : i_s0_valid);

  // State, read pipeline and output pixel register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SYNC;
      sel_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      blk_pend_q <= 1'b0;
      pixel_q    <= FALLBACK_RGB;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rd_pend_q  <= run & i_enable;
      rd_sel_q   <= sel_d;
      blk_pend_q <= (state_q == BLANK) & i_enable;
      valid_q    <= rd_pend_q | blk_pend_q;
      if (rd_pend_q) begin
        if (uf_evt)        pixel_q <= FALLBACK_RGB;
        else if (rd_sel_q) pixel_q <= i_s1_pixel;
        else               pixel_q <= i_s0_pixel;
      end else if (blk_pend_q) begin
        pixel_q <= FALLBACK_RGB;
      end
    end
  end

  // Sticky underflow flag; clear wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst || i_clr_stat) uf_q <= 1'b0;
    else if (uf_evt)       uf_q <= 1'b1;
  end

`ifdef PIX_SRC_SCHED_UNDERFLOW_CNT_EN
  logic [15:0] cnt_q;
  // Saturating event counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || i_clr_stat)              cnt_q <= '0;
    else if (uf_evt && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign o_underflow_cnt = cnt_q;
`else
  assign o_underflow_cnt = 16'd0;
`endif

  assign o_pixel      = pixel_q;
  assign o_valid      = valid_q;
  assign o_active_sel = sel_q;
  assign o_state      = state_q;
  assign o_underflow  = uf_q;

endmodule

// File: tb/tb_pix_src_sched.sv
// Randomized + directed bench for pix_src_sched. A frame-level reference model
// predicts strobes, state and flags each cycle; pixel results are queued with
// their due cycle and checked by an independent negedge monitor.
module tb_pix_src_sched;
  localparam int          PW = 24;
  localparam logic [23:0] FB = 24'hA5C3E1;

  logic clk = 1'b0;
  logic rst, i_enable, i_newline, i_newframe, i_sel, i_blank, i_clr_stat;
  logic o_s0_rd, o_s1_rd, o_s0_newline, o_s1_newline, o_s0_newframe, o_s1_newframe;
  logic [PW-1:0] i_s0_pixel, i_s1_pixel, o_pixel;
  logic i_s0_valid, i_s1_valid, o_valid, o_active_sel, o_underflow;
  logic [1:0]  o_state;
  logic [15:0] o_underflow_cnt;

  pix_src_sched #(.BITS_PER_COLOR(8), .FALLBACK_RGB(FB)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_newline(i_newline),
    .i_newframe(i_newframe), .i_sel(i_sel), .i_blank(i_blank), .i_clr_stat(i_clr_stat),
    .o_s0_rd(o_s0_rd), .o_s1_rd(o_s1_rd), .o_s0_newline(o_s0_newline),
    .o_s1_newline(o_s1_newline), .o_s0_newframe(o_s0_newframe), .o_s1_newframe(o_s1_newframe),
    .i_s0_pixel(i_s0_pixel), .i_s1_pixel(i_s1_pixel), .i_s0_valid(i_s0_valid),
    .i_s1_valid(i_s1_valid), .o_pixel(o_pixel), .o_valid(o_valid),
    .o_active_sel(o_active_sel), .o_state(o_state), .o_underflow(o_underflow),
    .o_underflow_cnt(o_underflow_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0, errs = 0;
  bit mon_on = 0;

  typedef struct { int due; logic [23:0] pix; } exp_t;
  exp_t q[$];

  // reference model: frame mode (0 sync, 1 run, 2 blank), latched select,
  // flag/count, and the source response promised for next cycle
  int          mst;
  bit          msel, mflag;
  int          mcnt;
  bit          pend, pend_sel, pend_v;
  logic [23:0] pend_pix;
  bit          use_fix = 0;
  logic [23:0] fix_pix = 24'h112233;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // output monitor: o_valid must appear exactly at the due cycle with the queued pixel
  always @(negedge clk) begin
    if (mon_on) begin
      bit due_now;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      due_now = (q.size() > 0 && q[0].due == cyc);
      chk("o_valid", {31'd0, o_valid}, {31'd0, due_now});
      if (due_now) begin
        exp_t e;
        e = q.pop_front();
        if (o_valid === 1'b1) chk("o_pixel", {8'd0, o_pixel}, {8'd0, e.pix});
      end
    end
  end

  task automatic step(input bit en, nl, nf, sel, blk, clr, rs, input int vpct);
    bit run, es, evt;
    logic [5:0] exp_str, act_str;
    @(posedge clk); #1;
    rst = rs; i_enable = en; i_newline = nl; i_newframe = nf;
    i_sel = sel; i_blank = blk; i_clr_stat = clr;
    // unsolicited valids must be ignored
    i_s0_valid = 1'($urandom_range(1)); i_s0_pixel = 24'($urandom);
    i_s1_valid = 1'($urandom_range(1)); i_s1_pixel = 24'($urandom);
    if (pend) begin
      if (pend_sel) begin i_s1_valid = pend_v; i_s1_pixel = pend_pix; end
      else          begin i_s0_valid = pend_v; i_s0_pixel = pend_pix; end
    end
    #1;
    run = (mst == 1);
    es  = nf ? sel : msel;
    exp_str = {run & en & ~es, run & en & es, run & nl & ~es, run & nl & es,
               run & nf & ~es, run & nf & es};
    act_str = {o_s0_rd, o_s1_rd, o_s0_newline, o_s1_newline, o_s0_newframe, o_s1_newframe};
    chk("strobes", {26'd0, act_str}, {26'd0, exp_str});
    chk("o_state", {30'd0, o_state}, 32'(mst));
    chk("o_active_sel", {31'd0, o_active_sel}, {31'd0, msel});
    chk("o_underflow", {31'd0, o_underflow}, {31'd0, mflag});
`ifdef PIX_SRC_SCHED_UNDERFLOW_CNT_EN
    chk("o_underflow_cnt", {16'd0, o_underflow_cnt}, 32'(mcnt));
`else
    chk("o_underflow_cnt", {16'd0, o_underflow_cnt}, 32'd0);
`endif
    evt = pend && !pend_v;
    if (rs) begin
      exp_t keep[$];
      foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
      q = keep;
      mst = 0; msel = 0; mflag = 0; mcnt = 0; pend = 0;
    end else begin
      if (clr) begin mflag = 0; mcnt = 0; end
      else if (evt) begin mflag = 1; if (mcnt < 65535) mcnt++; end
      pend = 0;
      if (run && en) begin
        exp_t e;
        pend = 1; pend_sel = es;
        pend_v = ($urandom_range(99) < vpct);
        pend_pix = use_fix ? fix_pix : 24'($urandom);
        e.due = cyc + 2; e.pix = pend_v ? pend_pix : FB;
        q.push_back(e);
      end
      if (mst == 2 && en) begin
        exp_t e;
        e.due = cyc + 2; e.pix = FB;
        q.push_back(e);
      end
      if (nf) begin msel = sel; mst = blk ? 2 : 1; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 100);
  endtask

  initial begin
    rst = 1; i_enable = 0; i_newline = 0; i_newframe = 0; i_sel = 0; i_blank = 0;
    i_clr_stat = 0; i_s0_valid = 0; i_s1_valid = 0; i_s0_pixel = '0; i_s1_pixel = '0;
    repeat (2) @(posedge clk);
    mst = 0; msel = 0; mflag = 0; mcnt = 0; pend = 0;
    step(0, 0, 0, 0, 0, 0, 1, 100);
    mon_on = 1;
    // reset state: enable without a frame start does nothing
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 100);
    chk("pixel_after_reset", {8'd0, o_pixel}, {8'd0, FB});
    // frame on source 0, fixed data
    step(0, 0, 1, 0, 0, 0, 0, 100);
    use_fix = 1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 100);
    use_fix = 0;
    idle(3);
    // select changes mid-frame: reads stay on source 0
    for (int i = 0; i < 3; i++) step(1, i == 1, 0, 1, 0, 0, 0, 100);
    // switching frame start (with newline) goes to source 1, then two underflows
    step(0, 1, 1, 1, 0, 0, 0, 100);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
    idle(3);
    // blank frame then back to run
    step(0, 0, 1, 1, 1, 0, 0, 100);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0, 0, 0, 100);
    idle(2);
    // clear in the same cycle as an underflow event
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 100);
    idle(3);
    // reset mid-frame with a read in the reset cycle
    step(1, 0, 0, 0, 0, 0, 0, 100);
    step(1, 0, 0, 0, 0, 0, 1, 100);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) < 60, $urandom_range(99) < 10, $urandom_range(99) < 5,
           1'($urandom_range(1)), $urandom_range(99) < 25, $urandom_range(99) < 3,
           $urandom_range(999) < 8, 80);
    idle(3);
`ifdef PIX_SRC_SCHED_UNDERFLOW_CNT_EN
    // saturation: drive the counter to 16'hFFFF and beyond
    step(0, 0, 1, 0, 0, 1, 0, 100);
    for (int i = 0; i < 65540; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 100);
    idle(3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
